// File: rtl/dma_buf_pkg.sv
// Shared types and defaults for the DMA read-side buffer line packer.
package dma_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int PACK_DEF   = 4;
  localparam int ADDR_W_DEF = 12;

  function automatic int line_w(input int data_w, input int pack);
    return data_w * pack;
  endfunction

endpackage

// File: rtl/dma_rd_line_packer_if.sv
// Word stream from the read DMA into the line packer; no ready, the sink always accepts.
interface dma_rd_line_packer_if #(
  parameter int DATA_W = 32
) ();

  logic [DATA_W-1:0] data;
  logic              data_vld;
  logic              done;

  modport master (output data, data_vld, done);
  modport slave  (input  data, data_vld, done);

endinterface

// File: rtl/dma_rd_line_packer_pack.sv
// Word-slot array: fills PACK slots LSB first, zero-pads a short line on done.
// Combinational line_we_o/line_o for the word accepted this cycle; no backpressure.
module line_shift_pack #(
  parameter int DATA_W = 32,
  parameter int PACK   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   vld_i,
  input  logic [DATA_W-1:0]      word_i,
  input  logic                   done_i,
  output logic                   line_we_o,
  output logic [DATA_W*PACK-1:0] line_o
);

  localparam int IDX_W = $clog2(PACK);

  logic [IDX_W-1:0]             fill_q, fill_d;
  logic [PACK-1:0][DATA_W-1:0]  slot_q, slot_d;
  logic [PACK-1:0][DATA_W-1:0]  line_arr;
  logic                         last_word;

  assign last_word = vld_i && (fill_q == IDX_W'(PACK - 1));
  assign line_o    = line_arr;

  // Slots are cleared after every line, so unfilled slots already read as zero padding.
  always_comb begin
    slot_d    = slot_q;
    fill_d    = fill_q;
    line_arr  = slot_q;
    line_we_o = 1'b0;
    if (vld_i) line_arr[fill_q] = word_i;
    if (last_word || (done_i && (vld_i || (fill_q != '0)))) line_we_o = 1'b1;
    if (clr_i || line_we_o || done_i) begin
      slot_d = '0;
      fill_d = '0;
    end else if (vld_i) begin
      slot_d[fill_q] = word_i;
      fill_d         = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      fill_q <= '0;
    end else begin
      slot_q <= slot_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/dma_rd_line_packer.sv
// Packs DMA words into buffer lines with address generation, line count and overflow guard.
// Write one cycle after the completing word; load_done one cycle after; never stalls the DMA.
module dma_rd_line_packer
  import dma_buf_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int PACK   = PACK_DEF,
  parameter  int ADDR_W = ADDR_W_DEF,
  localparam int LINE_W = line_w(DATA_W, PACK)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [ADDR_W-1:0]      base_addr_i,
  dma_rd_line_packer_if.slave    wrd_if,
  output logic                   buf_we_o,
  output logic [ADDR_W-1:0]      buf_addr_o,
  output logic [LINE_W-1:0]      buf_wdata_o,
  output logic                   busy_o,
  output logic                   load_done_o,
  output logic [ADDR_W:0]        lines_o,
  output logic                   ovf_o
);

  localparam logic [ADDR_W:0] LINES_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, waddr_q, waddr_d;
  logic [ADDR_W:0]     lines_q, lines_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                ovf_q, ovf_d, we_q, we_d, busy_q, busy_d, ldone_q, ldone_d;
  logic                run_en, pk_vld, pk_done, line_we;
  logic [LINE_W-1:0]   line_dat;

  // start_i wins over a coincident word or done, which are dropped.
  assign run_en  = (state_q == ST_RUN) && !start_i;
  assign pk_vld  = run_en && wrd_if.data_vld;
  assign pk_done = run_en && wrd_if.done;

  line_shift_pack #(.DATA_W(DATA_W), .PACK(PACK)) u_pack (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (start_i),
    .vld_i     (pk_vld),
    .word_i    (wrd_if.data),
    .done_i    (pk_done),
    .line_we_o (line_we),
    .line_o    (line_dat)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    lines_d = lines_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    we_d    = 1'b0;
    ldone_d = 1'b0;
    if (start_i) begin
      state_d = ST_RUN;
      addr_d  = base_addr_i;
      lines_d = '0;
      ovf_d   = 1'b0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (line_we) begin
            // A full buffer swallows further lines but the load still completes.
            if (lines_q == LINES_MAX) begin
              ovf_d = 1'b1;
            end else begin
              we_d    = 1'b1;
              waddr_d = addr_q;
              wdata_d = line_dat;
              addr_d  = addr_q + 1'b1;
              lines_d = lines_q + 1'b1;
            end
          end
          if (pk_done) state_d = ST_FLUSH;
        end
        ST_FLUSH: begin
          state_d = ST_IDLE;
          ldone_d = 1'b1;
          busy_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      lines_q <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      ldone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      lines_q <= lines_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      ldone_q <= ldone_d;
    end
  end

  assign buf_we_o    = we_q;
  assign buf_addr_o  = waddr_q;
  assign buf_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign load_done_o = ldone_q;
  assign lines_o     = lines_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_dma_rd_line_packer.sv
// Drives two packers (12-bit and 2-bit address) from one word stream against a load-level model.
module tb_dma_rd_line_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_i;
  logic [11:0]  base_addr;

  dma_rd_line_packer_if #(.DATA_W(32)) wif ();

  logic         we_a, busy_a, ld_a, ovf_a;
  logic [11:0]  addr_a;
  logic [127:0] wd_a;
  logic [12:0]  lines_a;
  logic         we_b, busy_b, ld_b, ovf_b;
  logic [1:0]   addr_b;
  logic [127:0] wd_b;
  logic [2:0]   lines_b;

  dma_rd_line_packer dut_a (
    .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr), .wrd_if(wif),
    .buf_we_o(we_a), .buf_addr_o(addr_a), .buf_wdata_o(wd_a), .busy_o(busy_a),
    .load_done_o(ld_a), .lines_o(lines_a), .ovf_o(ovf_a)
  );

  dma_rd_line_packer #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr[1:0]), .wrd_if(wif),
    .buf_we_o(we_b), .buf_addr_o(addr_b), .buf_wdata_o(wd_b), .busy_o(busy_b),
    .load_done_o(ld_b), .lines_o(lines_b), .ovf_o(ovf_b)
  );

  typedef struct {
    int           stamp;
    int           addr;
    logic [127:0] dat;
  } wr_t;

  wr_t  act_a[$], act_b[$], exp_a[$], exp_b[$];
  int   act_da[$], act_db[$], exp_d[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  // Load-level model: words since start, lines written per DUT, overflow per DUT.
  int          aw[2] = '{12, 2};
  int          m_base;
  int          m_lines[2];
  bit          m_ovf[2];
  bit          m_run;
  logic [31:0] m_words[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we_a === 1'b1) act_a.push_back('{cyc, int'(addr_a), wd_a});
    if (we_b === 1'b1) act_b.push_back('{cyc, int'(addr_b), wd_b});
    if (ld_a === 1'b1) begin act_da.push_back(cyc); chk("busy_at_done_a", busy_a, 0); end
    if (ld_b === 1'b1) begin act_db.push_back(cyc); chk("busy_at_done_b", busy_b, 0); end
  end

  task automatic model_step(input bit vld, input logic [31:0] d, input bit dn, input int c);
    logic [127:0] line;
    wr_t          w;
    if (!m_run) return;
    if (vld) m_words.push_back(d);
    if (m_words.size() == 4 || (dn && m_words.size() > 0)) begin
      line = '0;
      for (int k = 0; k < m_words.size(); k++) line |= 128'(m_words[k]) << (32 * k);
      for (int dd = 0; dd < 2; dd++) begin
        if (m_lines[dd] < (1 << aw[dd])) begin
          w = '{c + 1, (m_base + m_lines[dd]) % (1 << aw[dd]), line};
          if (dd == 0) exp_a.push_back(w); else exp_b.push_back(w);
          m_lines[dd]++;
        end else begin
          m_ovf[dd] = 1'b1;
        end
      end
      m_words.delete();
    end
    if (dn) begin
      exp_d.push_back(c + 2);
      m_run = 1'b0;
    end
  endtask

  task automatic drive(input bit vld, input logic [31:0] d, input bit dn);
    @(negedge clk);
    start_i      = 1'b0;
    rst          = 1'b0;
    wif.data_vld = vld;
    wif.data     = vld ? d : $urandom();
    wif.done     = dn;
    model_step(vld, d, dn, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0, 1'b0);
  endtask

  task automatic start_load(input logic [11:0] base);
    @(negedge clk);
    start_i      = 1'b1;
    base_addr    = base;
    wif.data_vld = 1'($urandom_range(0, 1));
    wif.data     = $urandom();
    wif.done     = 1'($urandom_range(0, 1));
    m_run = 1'b1; m_base = int'(base); m_lines = '{0, 0}; m_ovf = '{0, 0};
    m_words.delete();
    @(negedge clk);
    start_i = 1'b0; wif.data_vld = 1'b0; wif.done = 1'b0;
    chk("busy_after_start_a", busy_a, 1);
    chk("busy_after_start_b", busy_b, 1);
    chk("lines_after_start_a", lines_a, 0);
    chk("ovf_after_start_b", ovf_b, 0);
  endtask

  // late < 0: no done; late == 0: done with last word; late > 0: done alone late cycles after.
  task automatic run_words(input int n, input int gap_max, input int late,
                           input logic [31:0] w0, input bit seq);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, seq ? w0 + 32'(i) : $urandom(), (late == 0) && (i == n - 1));
      if (i < n - 1) idle($urandom_range(0, gap_max));
    end
    if (late > 0) begin
      idle(late - 1);
      drive(1'b0, 32'h0, 1'b1);
    end
  endtask

  task automatic cmp_wr(input string nm, input wr_t a[$], input wr_t e[$]);
    chk({nm, "_wr_count"}, 128'(a.size()), 128'(e.size()));
    for (int i = 0; i < a.size() && i < e.size(); i++) begin
      chk({nm, "_wr_cycle"}, 128'(a[i].stamp), 128'(e[i].stamp));
      chk({nm, "_wr_addr"},  128'(a[i].addr),  128'(e[i].addr));
      chk({nm, "_wr_data"},  a[i].dat,         e[i].dat);
    end
  endtask

  task automatic cmp_done(input string nm, input int a[$], input int e[$]);
    chk({nm, "_done_count"}, 128'(a.size()), 128'(e.size()));
    for (int i = 0; i < a.size() && i < e.size(); i++)
      chk({nm, "_done_cycle"}, 128'(a[i]), 128'(e[i]));
  endtask

  task automatic finish_load(input string nm);
    idle(5);
    cmp_wr({nm, "_a"}, act_a, exp_a);
    cmp_wr({nm, "_b"}, act_b, exp_b);
    cmp_done({nm, "_a"}, act_da, exp_d);
    cmp_done({nm, "_b"}, act_db, exp_d);
    chk({nm, "_lines_a"}, lines_a, 128'(m_lines[0]));
    chk({nm, "_lines_b"}, lines_b, 128'(m_lines[1]));
    chk({nm, "_ovf_a"}, ovf_a, m_ovf[0]);
    chk({nm, "_ovf_b"}, ovf_b, m_ovf[1]);
    chk({nm, "_busy_a"}, busy_a, 0);
    act_a.delete(); act_b.delete(); exp_a.delete(); exp_b.delete();
    act_da.delete(); act_db.delete(); exp_d.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_we"},    {we_a, we_b}, 0);
    chk({nm, "_busy"},  {busy_a, busy_b}, 0);
    chk({nm, "_ldone"}, {ld_a, ld_b}, 0);
    chk({nm, "_lines"}, {lines_a, lines_b}, 0);
    chk({nm, "_ovf"},   {ovf_a, ovf_b}, 0);
    chk({nm, "_addr"},  {addr_a, addr_b}, 0);
    chk({nm, "_wdata"}, wd_a | wd_b, 0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; base_addr = '0;
    wif.data = '0; wif.data_vld = 1'b0; wif.done = 1'b0;
    m_run = 1'b0; m_lines = '{0, 0}; m_ovf = '{0, 0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    run_words(3, 0, 0, 32'h55, 1'b1);
    finish_load("idle_ignored");

    start_load(12'h010);
    run_words(8, 0, 0, 32'h0, 1'b1);
    finish_load("full_lines");

    start_load(12'h040);
    run_words(6, 0, 0, 32'hA0, 1'b1);
    finish_load("partial");

    start_load(12'h123);
    run_words(4, 0, 3, 32'h11, 1'b1);
    finish_load("late_done");

    start_load(12'hFFF);
    run_words(20, 0, 0, 32'h100, 1'b1);
    finish_load("wrap_ovf");

    start_load(12'h200);
    run_words(2, 0, -1, 32'hE0, 1'b1);
    start_load(12'h020);
    run_words(4, 0, 0, 32'hC0, 1'b1);
    finish_load("abort");

    start_load(12'h300);
    run_words(3, 0, -1, 32'hD0, 1'b1);
    @(negedge clk);
    rst = 1'b1; wif.data_vld = 1'b0; wif.done = 1'b0;
    m_run = 1'b0; m_words.delete(); m_lines = '{0, 0}; m_ovf = '{0, 0};
    @(negedge clk);
    rst = 1'b0;
    chk_zero("mid_reset");
    run_words(5, 0, 0, 32'hF0, 1'b1);
    finish_load("after_reset");

    for (int t = 0; t < 14; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        start_load(12'($urandom()));
        run_words($urandom_range(1, 6), 1, -1, 32'h0, 1'b0);
      end
      start_load(12'($urandom()));
      run_words($urandom_range(1, 22), $urandom_range(0, 2),
                ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0, 32'h0, 1'b0);
      finish_load("random");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
